imem_access_arbiter: RTL

// - Owns the single port of the instruction memory; shares it between the core fetch port and the program loader.
// - After reset, holds the core in LOAD so the loader can write the image as 32-bit words.
// - In RUN, serves fetches with 1-cycle read latency.
// - Still accepts loader patch writes in RUN, under a starvation limit.
// - Sits between the core fetch stage and the imem SRAM.

---
 rtl/imem_arb_pkg.sv | 18 +
 rtl/imem_arb_starve_cnt.sv | 37 +++
 rtl/imem_access_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory access arbiter.
package imem_arb_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // A word address is usable only if 4-aligned and the whole word fits in the array.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned mem_bytes);
        logic [31:0] last_word;
        last_word = 32'(mem_bytes - 4);
        return (addr[1:0] == 2'b00) && (addr <= last_word);
    endfunction

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating starvation counter: counts loader wait cycles, flags when the limit is hit.
module imem_arb_starve_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/imem_access_arbiter.sv
// Single-port imem arbiter between core fetch and program loader (LOAD then RUN).
// Optional loader checksum output ld_csum is enabled by defining IMEM_ARB_CHECKSUM_EN.
module imem_access_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 108,
    parameter int unsigned ADDR_W    = 7,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_hold,
    output logic              err_oob
`ifdef IMEM_ARB_CHECKSUM_EN
    ,
    output logic [31:0]       ld_csum
`endif
);

    arb_state_t state_reg;
    logic       hold_reg;
    logic       rvalid_reg;
    logic       nop_reg;
    logic       err_reg;

    logic ld_in;
    logic if_in;
    logic ld_gnt;
    logic ld_wr;
    logic if_rd;
    logic at_max;
    logic force_ld;
    logic starve_inc;

    assign ld_in = in_range(ld_addr, MEM_BYTES);
    assign if_in = in_range(if_addr, MEM_BYTES);

    // Once the loader has waited MAX_WAIT cycles it wins over fetch.
    assign force_ld = at_max && ld_valid;

    always_comb begin
        ld_ready = 1'b0;
        if_gnt   = 1'b0;
        case (state_reg)
            LOAD: begin
                ld_ready = 1'b1;
            end
            RUN: begin
                ld_ready = at_max || !if_req;
                if_gnt   = if_req && !force_ld;
            end
            default: begin
                ld_ready = 1'b0;
                if_gnt   = 1'b0;
            end
        endcase
    end

    assign ld_gnt     = ld_valid && ld_ready;
    assign ld_wr      = ld_gnt && ld_in;
    assign if_rd      = if_gnt && if_in;
    assign starve_inc = (state_reg == RUN) && ld_valid && !ld_ready;

    imem_arb_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (ld_gnt),
        .at_max(at_max)
    );

    // Out-of-range accesses are consumed but never reach the SRAM port.
    always_comb begin
        mem_en    = ld_wr || if_rd;
        mem_we    = ld_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_wr) begin
            mem_addr  = ld_addr[ADDR_W-1:0];
            mem_wdata = ld_data;
        end else if (if_rd) begin
            mem_addr = if_addr[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= LOAD;
            hold_reg   <= 1'b1;
            rvalid_reg <= 1'b0;
            nop_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= if_gnt;
            nop_reg    <= if_gnt && !if_in;
            err_reg    <= (if_gnt && !if_in) || (ld_gnt && !ld_in);
            case (state_reg)
                LOAD: begin
                    if (ld_gnt && ld_last) begin
                        state_reg <= RUN;
                        hold_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    state_reg <= RUN;
                    hold_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= LOAD;
                    hold_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign core_hold = hold_reg;
    assign if_rvalid = rvalid_reg;
    assign err_oob   = err_reg;
    // SRAM output holds the last read, so a following write cannot disturb it.
    assign if_rdata  = rvalid_reg ? (nop_reg ? NOP_INSTR : mem_rdata) : 32'h0;

`ifdef IMEM_ARB_CHECKSUM_EN
    logic [31:0] csum_reg;
    logic        fresh_reg;
    logic [31:0] csum_base;
    logic [31:0] csum_add;

    assign csum_base = fresh_reg ? 32'h0 : csum_reg;
    assign csum_add  = ld_wr ? ld_data : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_reg  <= 32'h0;
            fresh_reg <= 1'b1;
        end else begin
            csum_reg  <= csum_base + csum_add;
            fresh_reg <= 1'b0;
        end
    end

    assign ld_csum = csum_reg;
`endif

endmodule
